// File: rtl/except_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : except_ctrl_pkg
// Description : Exception encodings, cause codes and FSM states shared by
//               the exception controller.
// Revision    : 1.0 - initial release
// ============================================================================
package except_ctrl_pkg;

  // One-hot exception encodings handed to CP0
  localparam logic [31:0] ENCODE_NONE    = 32'h0000_0000;
  localparam logic [31:0] ENCODE_INT0    = 32'h0000_0001;
  localparam logic [31:0] ENCODE_INT1    = 32'h0000_0002;
  localparam logic [31:0] ENCODE_INT2    = 32'h0000_0004;
  localparam logic [31:0] ENCODE_INT3    = 32'h0000_0008;
  localparam logic [31:0] ENCODE_INT4    = 32'h0000_0010;
  localparam logic [31:0] ENCODE_INT5    = 32'h0000_0020;
  localparam logic [31:0] ENCODE_INT6    = 32'h0000_0040;
  localparam logic [31:0] ENCODE_INT7    = 32'h0000_0080;
  localparam logic [31:0] ENCODE_ADEL_IF = 32'h0000_0100;
  localparam logic [31:0] ENCODE_RI      = 32'h0000_0200;
  localparam logic [31:0] ENCODE_OV      = 32'h0000_0400;
  localparam logic [31:0] ENCODE_TR      = 32'h0000_0800;
  localparam logic [31:0] ENCODE_SYS     = 32'h0000_1000;
  localparam logic [31:0] ENCODE_BP      = 32'h0000_2000;
  localparam logic [31:0] ENCODE_ADEL_LD = 32'h0000_4000;
  localparam logic [31:0] ENCODE_ADES    = 32'h0000_8000;
  localparam logic [31:0] ENCODE_ERET    = 32'h0001_0000;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  // Bit positions inside exc_flags_i; lower index means higher priority
  localparam int FLAG_ADEL_IF = 0;
  localparam int FLAG_RI      = 1;
  localparam int FLAG_OV      = 2;
  localparam int FLAG_TR      = 3;
  localparam int FLAG_SYS     = 4;
  localparam int FLAG_BP      = 5;
  localparam int FLAG_ADEL_LD = 6;
  localparam int FLAG_ADES    = 7;
  localparam int FLAG_ERET    = 8;
  localparam int NUM_FLAGS    = 9;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/except_ctrl_int_sync.sv
`default_nettype none
// ============================================================================
// Module      : int_sync
// Description : Two-flop synchroniser for the external interrupt lines.
// Revision    : 1.0 - initial release
// ============================================================================
module int_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] stage1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage1   <= '0;
      sync_out <= '0;
    end else begin
      stage1   <= async_in;
      sync_out <= stage1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/except_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : except_ctrl
// Description : Prioritises MEM-stage exceptions and interrupts, strobes CP0,
//               flushes the pipeline and redirects fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [8:0]  exc_flags_i,
  input  logic [31:0] inst_addr_i,
  input  logic        delay_slot_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic [7:0]  int_i,
  input  logic        time_int_i,
  output logic [7:0]  int_sync_o,
  output logic [31:0] excepttype_o,
  output logic        except_handle_o,
  output logic [31:0] exc_addr_o,
  output logic        exc_bd_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] target;
  logic [7:0]  sync_q;
  logic [7:0]  irq_lines;
  logic        irq_pending;
  logic [31:0] winner;
  logic [31:0] next_target;
  logic        accept;
  logic        unused_bits;

  int_sync #(.WIDTH(8)) u_int_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (int_i),
    .sync_out (sync_q)
  );

  // The timer bypasses the synchroniser: it is already in the clk domain
  assign int_sync_o = {sync_q[7] | time_int_i, sync_q[6:0]};

  always_comb begin
    irq_lines   = cause_i[15:8] & status_i[15:8];
    irq_pending = status_i[0] & ~status_i[1] & (|irq_lines);
    winner      = ENCODE_NONE;
    if (irq_pending) begin
      // Ascending scan so the highest pending line overwrites lower ones
      for (int n = 0; n < 8; n++) begin
        if (irq_lines[n]) winner = ENCODE_INT0 << n;
      end
    end else begin
      for (int f = NUM_FLAGS - 1; f >= 0; f--) begin
        if (exc_flags_i[f]) winner = ENCODE_ADEL_IF << f;
      end
    end
  end

  assign next_target = (winner == ENCODE_ERET) ? epc_i : EXC_VECTOR;
  assign accept      = (state == ST_IDLE) && valid_i && (winner != ENCODE_NONE);
  assign busy_o      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      target           <= '0;
      excepttype_o     <= ENCODE_NONE;
      except_handle_o  <= 1'b0;
      exc_addr_o       <= '0;
      exc_bd_o         <= 1'b0;
      flush_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state           <= ST_FLUSH;
            cnt             <= CNT_LOAD;
            target          <= next_target;
            excepttype_o    <= winner;
            except_handle_o <= 1'b1;
            exc_addr_o      <= inst_addr_i;
            exc_bd_o        <= delay_slot_i;
            flush_o         <= 1'b1;
            if (FLUSH_CYCLES == 1) begin
              redirect_valid_o <= 1'b1;
              redirect_pc_o    <= next_target;
            end
          end
        end
        ST_FLUSH: begin
          except_handle_o <= 1'b0;
          excepttype_o    <= ENCODE_NONE;
          if (cnt == 3'd0) begin
            state            <= ST_IDLE;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
          end else begin
            cnt <= cnt - 3'd1;
            // Redirect lands in the last flush cycle
            if (cnt == 3'd1) begin
              redirect_valid_o <= 1'b1;
              redirect_pc_o    <= target;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

endmodule
`default_nettype wire
